// File: rtl/cpu_bus_serializer.sv
// cpu_bus_serializer: runs one CPU access as PIN_W-wide address beats, then write- or read-data beats,
// LSB slice first, with pin_ready inserting wait states.
module cpu_bus_serializer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int PIN_W  = 8,
   localparam int NA   = ADDR_W / PIN_W,
   localparam int ND   = DATA_W / PIN_W,
   localparam int NMAX = NA > ND ? NA : ND,
   localparam int BW   = NMAX > 1 ? $clog2(NMAX) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_cpu_req,
   input  logic              i_cpu_we,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic [DATA_W-1:0] o_cpu_rdata,
   output logic              o_cpu_busy,
   output logic              o_cpu_done,
   output logic [PIN_W-1:0]  o_pin_addr,
   output logic [PIN_W-1:0]  o_pin_wdata,
   input  logic [PIN_W-1:0]  i_pin_rdata,
   output logic              o_pin_oe,
   output logic [1:0]        o_pin_phase,
   output logic [BW-1:0]     o_pin_beat,
   input  logic              i_pin_ready
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ADDR  = 3'd1;
   localparam logic [2:0] S_WDATA = 3'd2;
   localparam logic [2:0] S_RDATA = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   generate
      if (ADDR_W % PIN_W != 0 || DATA_W % PIN_W != 0) begin : g_width_check
         $error("cpu_bus_serializer: ADDR_W and DATA_W must be multiples of PIN_W");
      end
   endgenerate

   logic [2:0]        r_state;
   logic [BW-1:0]     r_beat;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_shadow;
   logic [DATA_W-1:0] r_rdata;
   logic [PIN_W-1:0]  r_pin_addr;
   logic [PIN_W-1:0]  r_pin_wdata;
   logic [BW-1:0]     w_beat_nxt;
   logic              w_a_last;
   logic              w_d_last;
   logic [DATA_W-1:0] w_shadow_nxt;

   assign w_beat_nxt = r_beat + 1'b1;
   assign w_a_last   = r_beat == BW'(NA - 1);
   assign w_d_last   = r_beat == BW'(ND - 1);

   // shadow with the current read beat merged in, so the final beat lands in cpu_rdata on entry to DONE
   always_comb begin
      w_shadow_nxt = r_shadow;
      w_shadow_nxt[r_beat*PIN_W +: PIN_W] = i_pin_rdata;
   end

   // pin slices are registered so they hold their last driven value outside their own phase
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_beat      <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_shadow    <= '0;
         r_rdata     <= '0;
         r_pin_addr  <= '0;
         r_pin_wdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (i_cpu_req) begin
               r_state    <= S_ADDR;
               r_beat     <= '0;
               r_we       <= i_cpu_we;
               r_addr     <= i_cpu_addr;
               r_wdata    <= i_cpu_wdata;
               r_pin_addr <= i_cpu_addr[PIN_W-1:0];
            end
            S_ADDR: if (i_pin_ready) begin
               r_beat <= w_a_last ? '0 : w_beat_nxt;
               if (w_a_last) begin
                  r_state <= r_we ? S_WDATA : S_RDATA;
                  if (r_we) r_pin_wdata <= r_wdata[PIN_W-1:0];
               end else r_pin_addr <= r_addr[w_beat_nxt*PIN_W +: PIN_W];
            end
            S_WDATA: if (i_pin_ready) begin
               r_beat <= w_d_last ? '0 : w_beat_nxt;
               if (w_d_last) r_state <= S_DONE;
               else r_pin_wdata <= r_wdata[w_beat_nxt*PIN_W +: PIN_W];
            end
            S_RDATA: if (i_pin_ready) begin
               r_beat   <= w_d_last ? '0 : w_beat_nxt;
               r_shadow <= w_shadow_nxt;
               if (w_d_last) begin
                  r_state <= S_DONE;
                  r_rdata <= w_shadow_nxt;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_pin_phase = r_state == S_ADDR  ? 2'd1 :
                        r_state == S_WDATA ? 2'd2 :
                        r_state == S_RDATA ? 2'd3 : 2'd0;
   assign o_pin_oe    = r_state == S_WDATA;
   assign o_cpu_busy  = r_state != S_IDLE;
   assign o_cpu_done  = r_state == S_DONE;
   assign o_pin_beat  = r_beat;
   assign o_pin_addr  = r_pin_addr;
   assign o_pin_wdata = r_pin_wdata;
   assign o_cpu_rdata = r_rdata;
endmodule

// File: tb/tb_cpu_bus_serializer.sv
// tb_cpu_bus_serializer: scoreboard bench for a 32/32/8 instance and a 16/8/4 instance;
// expected words and latencies come from the access rules, observed words are rebuilt from pin beats.
module tb_cpu_bus_serializer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req[2], we[2], rdy[2];
   logic [31:0] addr[2], wd[2];
   logic [7:0]  prd[2];
   logic [31:0] rd0;
   logic [7:0]  rd1, pa0, pw0;
   logic [3:0]  pa1, pw1;
   logic        busy0, busy1, done0, done1, oe0, oe1;
   logic [1:0]  ph0, ph1, bt0, bt1;

   cpu_bus_serializer u0 (
      .clk(clk), .rst_n(rst_n), .i_cpu_req(req[0]), .i_cpu_we(we[0]), .i_cpu_addr(addr[0]),
      .i_cpu_wdata(wd[0]), .o_cpu_rdata(rd0), .o_cpu_busy(busy0), .o_cpu_done(done0),
      .o_pin_addr(pa0), .o_pin_wdata(pw0), .i_pin_rdata(prd[0]), .o_pin_oe(oe0),
      .o_pin_phase(ph0), .o_pin_beat(bt0), .i_pin_ready(rdy[0]));

   cpu_bus_serializer #(.ADDR_W(16), .DATA_W(8), .PIN_W(4)) u1 (
      .clk(clk), .rst_n(rst_n), .i_cpu_req(req[1]), .i_cpu_we(we[1]), .i_cpu_addr(addr[1][15:0]),
      .i_cpu_wdata(wd[1][7:0]), .o_cpu_rdata(rd1), .o_cpu_busy(busy1), .o_cpu_done(done1),
      .o_pin_addr(pa1), .o_pin_wdata(pw1), .i_pin_rdata(prd[1][3:0]), .o_pin_oe(oe1),
      .o_pin_phase(ph1), .o_pin_beat(bt1), .i_pin_ready(rdy[1]));

   logic [31:0] o_rd[2];
   logic [7:0]  o_pa[2], o_pw[2];
   logic        o_busy[2], o_done[2], o_oe[2];
   logic [1:0]  o_ph[2], o_bt[2];

   always_comb begin
      o_rd[0] = rd0;             o_rd[1] = {24'd0, rd1};
      o_pa[0] = pa0;             o_pa[1] = {4'd0, pa1};
      o_pw[0] = pw0;             o_pw[1] = {4'd0, pw1};
      o_busy[0] = busy0;         o_busy[1] = busy1;
      o_done[0] = done0;         o_done[1] = done1;
      o_oe[0] = oe0;             o_oe[1] = oe1;
      o_ph[0] = ph0;             o_ph[1] = ph1;
      o_bt[0] = bt0;             o_bt[1] = bt1;
   end

   function automatic int na(input int k); return 4; endfunction
   function automatic int nd(input int k); return k != 0 ? 2 : 4; endfunction
   function automatic int pw(input int k); return k != 0 ? 4 : 8; endfunction
   function automatic logic [31:0] amask(input int k); return k != 0 ? 32'h0000FFFF : 32'hFFFFFFFF; endfunction
   function automatic logic [31:0] dmask(input int k); return k != 0 ? 32'h000000FF : 32'hFFFFFFFF; endfunction

   typedef struct {
      int          k;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
      bit          b2b;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] last_rd[2];
   int          wt[8];
   int          nchk = 0, nerr = 0;
   int          cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      nchk++;
      if (act !== expv) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   task automatic chk_zero(input int k);
      chk("rst_rdata", o_rd[k], 0);
      chk("rst_busy", o_busy[k], 0);
      chk("rst_done", o_done[k], 0);
      chk("rst_pin_addr", o_pa[k], 0);
      chk("rst_pin_wdata", o_pw[k], 0);
      chk("rst_oe", o_oe[k], 0);
      chk("rst_phase", o_ph[k], 0);
      chk("rst_beat", o_bt[k], 0);
   endtask

   // monitor: rebuilds each access from the pins and pops the scoreboard on every done pulse
   int          acc[2], last_done[2], cnt_a[2], cnt_w[2];
   logic [31:0] col_a[2], col_w[2];
   logic        pbusy[2], pdone[2], prdy[2];
   logic [1:0]  pph[2], pbt[2];
   logic [7:0]  ppa[2], ppw[2];

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
               pbusy[k] = 0; pdone[k] = 0; prdy[k] = 1; pph[k] = 0;
            end else begin
               if (o_busy[k] && !pbusy[k]) begin
                  acc[k] = cyc - 1;
                  cnt_a[k] = 0; cnt_w[k] = 0; col_a[k] = 0; col_w[k] = 0;
               end
               if (o_ph[k] != 0 && o_ph[k] == pph[k] && !prdy[k]) begin
                  chk("hold_beat", o_bt[k], pbt[k]);
                  chk("hold_pin_addr", o_pa[k], ppa[k]);
                  chk("hold_pin_wdata", o_pw[k], ppw[k]);
               end
               if (o_ph[k] == 1) begin
                  chk("oe_addr_phase", o_oe[k], 0);
                  if (rdy[k]) begin
                     chk("addr_beat_idx", o_bt[k], cnt_a[k]);
                     col_a[k] = col_a[k] | (32'(o_pa[k]) << (cnt_a[k] * pw(k)));
                     cnt_a[k]++;
                  end
               end
               if (o_ph[k] == 2) begin
                  chk("oe_wdata_phase", o_oe[k], 1);
                  if (rdy[k]) begin
                     chk("wdata_beat_idx", o_bt[k], cnt_w[k]);
                     col_w[k] = col_w[k] | (32'(o_pw[k]) << (cnt_w[k] * pw(k)));
                     cnt_w[k]++;
                  end
               end
               if (o_ph[k] == 3) begin
                  chk("oe_rdata_phase", o_oe[k], 0);
                  if (rdy[k]) begin
                     chk("rdata_beat_idx", o_bt[k], cnt_w[k]);
                     cnt_w[k]++;
                  end
               end
               if (o_done[k]) begin
                  chk("done_one_cycle", pdone[k], 0);
                  chk("done_busy", o_busy[k], 1);
                  chk("done_phase", o_ph[k], 0);
                  chk("done_oe", o_oe[k], 0);
                  if (!pdone[k]) begin
                     if (sb.size() == 0) begin
                        nchk++; nerr++;
                        $display("FAIL unexpected_done: inst %0d done with empty scoreboard", k);
                     end else begin
                        e = sb.pop_front();
                        chk("done_instance", k, e.k);
                        chk("addr_word", col_a[k], e.addr);
                        chk("addr_beats", cnt_a[k], na(k));
                        chk("data_beats", cnt_w[k], nd(k));
                        if (e.we) chk("wdata_word", col_w[k], e.wdata);
                        chk("cpu_rdata", o_rd[k], e.rdata);
                        chk("latency", cyc - acc[k], e.lat);
                        if (e.b2b) chk("b2b_gap", acc[k] - last_done[k], 1);
                        last_done[k] = cyc;
                     end
                  end
               end
               pbusy[k] = o_busy[k]; pdone[k] = o_done[k]; prdy[k] = rdy[k];
               pph[k] = o_ph[k]; pbt[k] = o_bt[k]; ppa[k] = o_pa[k]; ppw[k] = o_pw[k];
            end
         end
      end
   end

   task automatic clr_wt();
      for (int j = 0; j < 8; j++) wt[j] = 0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < 2; k++) req[k] = 0;
      repeat (n) begin
         for (int k = 0; k < 2; k++) begin rdy[k] = 1'($urandom); prd[k] = 8'($urandom); end
         @(posedge clk); #1;
      end
   endtask

   // one access: requests in the current IDLE cycle, then plays the beat plan in wt[], returns in IDLE
   task automatic access(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rw_in, input bit keep, input bit b2b);
      logic [31:0] rw, am, dm;
      int          tot;
      am = a & amask(k);
      dm = d & dmask(k);
      rw = rw_in & dmask(k);
      tot = 0;
      for (int j = 0; j < na(k) + nd(k); j++) tot += wt[j];
      sb.push_back('{k, w, am, dm, w ? last_rd[k] : rw, na(k) + nd(k) + 1 + tot, b2b});
      if (!w) last_rd[k] = rw;
      req[k] = 1; we[k] = w; addr[k] = am; wd[k] = dm;
      @(posedge clk); #1;
      req[k] = keep; we[k] = 1'($urandom); addr[k] = $urandom; wd[k] = $urandom;
      for (int j = 0; j < na(k) + nd(k); j++) begin
         for (int c = 0; c < wt[j]; c++) begin
            rdy[k] = 0; prd[k] = 8'($urandom);
            @(posedge clk); #1;
         end
         rdy[k] = 1;
         prd[k] = (j >= na(k) && !w) ? 8'(rw >> ((j - na(k)) * pw(k))) : 8'($urandom);
         @(posedge clk); #1;
      end
      rdy[k] = 1'($urandom); prd[k] = 8'($urandom);
      @(posedge clk); #1;
   endtask

   initial begin
      bit kp, nk;
      rst_n = 1;
      for (int k = 0; k < 2; k++) begin
         req[k] = 0; we[k] = 0; addr[k] = 0; wd[k] = 0; rdy[k] = 0; prd[k] = 0; last_rd[k] = 0;
      end
      clr_wt();
      #1 rst_n = 0;
      #1;
      chk_zero(0);
      chk_zero(1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      idle(2);

      access(0, 1, 32'h12345678, 32'hCAFEBABE, 32'h0, 0, 0);
      idle(1);
      access(0, 0, 32'h0000A5A5, 32'h0, 32'h44332211, 0, 0);
      idle(1);
      wt[1] = 3; wt[7] = 2;
      access(0, 0, 32'h89ABCDEF, 32'h0, 32'hDEADBEEF, 0, 0);
      clr_wt();
      idle(1);
      access(0, 1, 32'h11110000, 32'h01020304, 32'h0, 1, 0);
      access(0, 0, 32'h22220000, 32'h0, 32'h55667788, 1, 1);
      access(0, 1, 32'h33330000, 32'hF0E0D0C0, 32'h0, 0, 1);
      idle(2);

      kp = 0;
      for (int i = 0; i < 40; i++) begin
         for (int j = 0; j < 8; j++) wt[j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         nk = (i < 39) && ($urandom_range(0, 2) == 0);
         access(0, 1'($urandom), $urandom, $urandom, $urandom, nk, kp);
         kp = nk;
         if (!nk && $urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
      end
      clr_wt();
      idle(2);

      access(1, 1, 32'h0000ABCD, 32'h0000005A, 32'h0, 0, 0);
      idle(1);
      kp = 0;
      for (int i = 0; i < 12; i++) begin
         for (int j = 0; j < 8; j++) wt[j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         nk = (i < 11) && ($urandom_range(0, 2) == 0);
         access(1, 1'($urandom), $urandom, $urandom, $urandom, nk, kp);
         kp = nk;
         if (!nk) idle(1);
      end
      clr_wt();
      idle(2);

      // abandon an access mid-address at beat 2 with an asynchronous reset
      req[0] = 1; we[0] = 1; addr[0] = 32'hFEEDF00D; wd[0] = 32'h1;
      @(posedge clk); #1;
      req[0] = 0; rdy[0] = 1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_beat", o_bt[0], 2);
      chk("pre_rst_phase", o_ph[0], 1);
      chk("pre_rst_rdata", o_rd[0], last_rd[0]);
      rst_n = 0;
      #1;
      chk_zero(0);
      chk_zero(1);
      last_rd[0] = 0; last_rd[1] = 0;
      @(posedge clk); #1;
      rst_n = 1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("idle_after_rst_busy", o_busy[0], 0);
         chk("idle_after_rst_phase", o_ph[0], 0);
      end
      idle(2);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
